// File: rtl/core_pkg.sv
// Shared types and default widths for the core read-port arbiter.
package core_pkg;

  localparam int unsigned CORE_ADDR_WIDTH = 32;
  localparam int unsigned CORE_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

  // Opposite requester of a two-way arbitration.
  function automatic arb_owner_t other_owner(input arb_owner_t o);
    return (o == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
  endfunction

endpackage

// File: rtl/core_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, on contention the one not granted last wins.
module core_rr_arb2
  import core_pkg::*;
(
  input  logic [1:0] req,
  input  arb_owner_t last_grant,
  output arb_owner_t grant
);

  // req[0] is the fetch side, req[1] the LSU side.
  always_comb begin
    grant = last_grant;
    case (req)
      2'b01:   grant = OWN_INSTR;
      2'b10:   grant = OWN_DATA;
      2'b11:   grant = other_owner(last_grant);
      default: grant = last_grant;
    endcase
  end

endmodule

// File: rtl/core_read_arbiter.sv
// Shares one AXI-lite read port between fetch and LSU, one transaction in flight at a time.
module core_read_arbiter
  import core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CORE_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CORE_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] instr_ARADDR,
  input  logic                  instr_ARVALID,
  output logic                  instr_ARREADY,
  output logic [DATA_WIDTH-1:0] instr_RDATA,
  output logic                  instr_RVALID,
  input  logic                  instr_RREADY,
  input  logic [ADDR_WIDTH-1:0] data_ARADDR,
  input  logic                  data_ARVALID,
  output logic                  data_ARREADY,
  output logic [DATA_WIDTH-1:0] data_RDATA,
  output logic                  data_RVALID,
  input  logic                  data_RREADY,
  output logic [ADDR_WIDTH-1:0] mem_ARADDR,
  output logic                  mem_ARVALID,
  input  logic                  mem_ARREADY,
  input  logic [DATA_WIDTH-1:0] mem_RDATA,
  input  logic                  mem_RVALID,
  output logic                  mem_RREADY
);

  arb_state_t state_q;
  arb_owner_t owner_q;
  arb_owner_t last_q;
  arb_owner_t grant;
  logic [1:0] req;
  logic       addr_phase;
  logic       data_phase;

  assign req = {data_ARVALID, instr_ARVALID};

  core_rr_arb2 u_rr (
    .req        (req),
    .last_grant (last_q),
    .grant      (grant)
  );

  // Routing is suppressed while rst is high so an abandoned transaction shows no handshakes.
  assign addr_phase = !rst && (state_q == ARB_ADDR);
  assign data_phase = !rst && (state_q == ARB_DATA);

  // Arbitration FSM: grant in IDLE (last-grant follows every winner), then address, then data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_INSTR;
      last_q  <= OWN_INSTR;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|req) begin
            owner_q <= grant;
            last_q  <= grant;
            state_q <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (mem_ARVALID && mem_ARREADY) state_q <= ARB_DATA;
        end
        ARB_DATA: begin
          if (mem_RVALID && mem_RREADY) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Channel routing purely from state and owner; read data fans out unconditionally.
  always_comb begin
    instr_ARREADY = 1'b0;
    data_ARREADY  = 1'b0;
    instr_RVALID  = 1'b0;
    data_RVALID   = 1'b0;
    mem_ARADDR    = '0;
    mem_ARVALID   = 1'b0;
    mem_RREADY    = 1'b0;
    instr_RDATA   = mem_RDATA;
    data_RDATA    = mem_RDATA;
    if (addr_phase) begin
      if (owner_q == OWN_DATA) begin
        mem_ARADDR   = data_ARADDR;
        mem_ARVALID  = data_ARVALID;
        data_ARREADY = mem_ARREADY;
      end else begin
        mem_ARADDR    = instr_ARADDR;
        mem_ARVALID   = instr_ARVALID;
        instr_ARREADY = mem_ARREADY;
      end
    end
    if (data_phase) begin
      if (owner_q == OWN_DATA) begin
        mem_RREADY  = data_RREADY;
        data_RVALID = mem_RVALID;
      end else begin
        mem_RREADY   = instr_RREADY;
        instr_RVALID = mem_RVALID;
      end
    end
  end

endmodule

// File: tb/tb_core_read_arbiter.sv
// Bench for core_read_arbiter: memory responder, two requesters, protocol checker and data scoreboard.
module tb_core_read_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] instr_ARADDR, data_ARADDR, mem_ARADDR;
  logic          instr_ARVALID, instr_ARREADY, instr_RVALID, instr_RREADY;
  logic          data_ARVALID, data_ARREADY, data_RVALID, data_RREADY;
  logic [DW-1:0] instr_RDATA, data_RDATA, mem_RDATA;
  logic          mem_ARVALID, mem_ARREADY, mem_RVALID, mem_RREADY;

  core_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .instr_ARADDR(instr_ARADDR), .instr_ARVALID(instr_ARVALID), .instr_ARREADY(instr_ARREADY),
    .instr_RDATA(instr_RDATA), .instr_RVALID(instr_RVALID), .instr_RREADY(instr_RREADY),
    .data_ARADDR(data_ARADDR), .data_ARVALID(data_ARVALID), .data_ARREADY(data_ARREADY),
    .data_RDATA(data_RDATA), .data_RVALID(data_RVALID), .data_RREADY(data_RREADY),
    .mem_ARADDR(mem_ARADDR), .mem_ARVALID(mem_ARVALID), .mem_ARREADY(mem_ARREADY),
    .mem_RDATA(mem_RDATA), .mem_RVALID(mem_RVALID), .mem_RREADY(mem_RREADY)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int ar_delay = 0;
  int r_delay  = 0;
  bit rand_mem = 1'b0;

  logic [DW-1:0] exp_i[$];
  logic [DW-1:0] exp_d[$];
  bit            grant_log[$];

  // Reference of the shared port: free / address phase / data phase, owner and last winner.
  bit            m_free = 1'b1;
  bit            m_addr_ph = 1'b0;
  bit            m_owner = 1'b0;
  bit            m_last = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int            busy_cnt = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Memory contents seen by the bench: one fixed word, otherwise a hash of the address.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory slave: configurable AR and R latency, random RDATA while not valid.
  initial begin : mem_model
    bit            ar_hs, r_hs, arv, rst_s, have;
    logic [AW-1:0] ra, pa;
    int            ac, rc;
    mem_ARREADY = 1'b0; mem_RVALID = 1'b0; mem_RDATA = '0;
    have = 1'b0; ac = 0; rc = 0; pa = '0;
    forever begin
      @(negedge clk);
      ar_hs = mem_ARVALID && mem_ARREADY;
      r_hs  = mem_RVALID && mem_RREADY;
      arv   = mem_ARVALID;
      ra    = mem_ARADDR;
      rst_s = rst;
      @(posedge clk); #1;
      if (rst_s) begin
        mem_ARREADY = 1'b0; mem_RVALID = 1'b0; have = 1'b0; ac = 0; rc = 0;
      end else begin
        if (r_hs) begin mem_RVALID = 1'b0; have = 1'b0; rc = 0; end
        if (ar_hs) begin
          have = 1'b1; pa = ra; ac = 0; rc = 0;
          if (rand_mem) begin
            ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
          end
        end
        if (have) mem_ARREADY = 1'b0;
        else if (ar_delay == 0) mem_ARREADY = 1'b1;
        else if (arv) begin
          if (ac >= ar_delay) mem_ARREADY = 1'b1;
          else ac++;
        end else mem_ARREADY = 1'b0;
        if (have && !mem_RVALID) begin
          if (rc >= r_delay) begin mem_RVALID = 1'b1; mem_RDATA = mem_fn(pa); end
          else rc++;
        end
      end
      if (!mem_RVALID) mem_RDATA = $urandom;
    end
  end

  task automatic check_idle(input string nm);
    chk({instr_ARREADY, data_ARREADY, instr_RVALID, data_RVALID, mem_ARVALID, mem_RREADY} == 6'b0,
        {nm, "_handshakes"},
        64'({instr_ARREADY, data_ARREADY, instr_RVALID, data_RVALID, mem_ARVALID, mem_RREADY}), 64'd0);
    chk(mem_ARADDR == '0, {nm, "_mem_araddr"}, 64'(mem_ARADDR), 64'd0);
  endtask

  // Protocol checker: predicts the winner from the requests visible while the port is free.
  always @(negedge clk) begin : proto_check
    bit own_a, oth_a, own_rv, oth_rv, own_rr;
    chk(instr_RDATA == mem_RDATA && data_RDATA == mem_RDATA, "rdata_fanout",
        64'({instr_RDATA, data_RDATA}), 64'({mem_RDATA, mem_RDATA}));
    if (rst) begin
      check_idle("reset");
      m_free = 1'b1; m_addr_ph = 1'b0; m_last = 1'b0; busy_cnt = 0;
    end else if (m_free) begin
      check_idle("idle");
      if (instr_ARVALID || data_ARVALID) begin
        if (instr_ARVALID && data_ARVALID) m_owner = !m_last;
        else m_owner = data_ARVALID;
        m_last = m_owner;
        m_addr = m_owner ? data_ARADDR : instr_ARADDR;
        m_free = 1'b0; m_addr_ph = 1'b1; busy_cnt = 0;
        grant_log.push_back(m_owner);
      end
    end else if (m_addr_ph) begin
      own_a = m_owner ? data_ARREADY : instr_ARREADY;
      oth_a = m_owner ? instr_ARREADY : data_ARREADY;
      chk(mem_ARVALID === 1'b1, "addr_mem_arvalid", 64'(mem_ARVALID), 64'd1);
      chk(mem_ARADDR === m_addr, "addr_mem_araddr", 64'(mem_ARADDR), 64'(m_addr));
      chk(own_a === mem_ARREADY && oth_a === 1'b0, "addr_arready_route",
          64'({own_a, oth_a}), 64'({mem_ARREADY, 1'b0}));
      chk({instr_RVALID, data_RVALID, mem_RREADY} == 3'b0, "addr_r_quiet",
          64'({instr_RVALID, data_RVALID, mem_RREADY}), 64'd0);
      if (mem_ARVALID && mem_ARREADY) m_addr_ph = 1'b0;
    end else begin
      own_rv = m_owner ? data_RVALID : instr_RVALID;
      oth_rv = m_owner ? instr_RVALID : data_RVALID;
      own_rr = m_owner ? data_RREADY : instr_RREADY;
      chk({instr_ARREADY, data_ARREADY, mem_ARVALID} == 3'b0, "data_ar_quiet",
          64'({instr_ARREADY, data_ARREADY, mem_ARVALID}), 64'd0);
      chk(mem_RREADY === own_rr, "data_mem_rready", 64'(mem_RREADY), 64'(own_rr));
      chk(own_rv === mem_RVALID && oth_rv === 1'b0, "data_rvalid_route",
          64'({own_rv, oth_rv}), 64'({mem_RVALID, 1'b0}));
      if (mem_RVALID && mem_RREADY) m_free = 1'b1;
    end
    if (!m_free) begin
      busy_cnt++;
      if (busy_cnt > 300) begin
        chk(1'b0, "port_stuck_busy", 64'(busy_cnt), 64'd300);
        m_free = 1'b1; m_addr_ph = 1'b0; busy_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: each delivered beat must match the oldest expectation of its channel.
  always @(negedge clk) begin : sb_monitor
    logic [DW-1:0] e;
    if (rst) begin
      exp_i.delete(); exp_d.delete();
    end else begin
      if (instr_RVALID && instr_RREADY) begin
        if (exp_i.size() == 0) chk(1'b0, "instr_unexpected_beat", 64'(instr_RDATA), 64'd0);
        else begin
          e = exp_i.pop_front();
          chk(instr_RDATA === e, "instr_rdata", 64'(instr_RDATA), 64'(e));
        end
      end
      if (data_RVALID && data_RREADY) begin
        if (exp_d.size() == 0) chk(1'b0, "data_unexpected_beat", 64'(data_RDATA), 64'd0);
        else begin
          e = exp_d.pop_front();
          chk(data_RDATA === e, "data_rdata", 64'(data_RDATA), 64'(e));
        end
      end
    end
  end

  task automatic drive_ar(input bit ch, input bit v, input logic [AW-1:0] a);
    if (ch) begin data_ARVALID = v; data_ARADDR = a; end
    else begin instr_ARVALID = v; instr_ARADDR = a; end
  endtask

  task automatic set_rready(input bit ch, input bit v);
    if (ch) data_RREADY = v;
    else instr_RREADY = v;
  endtask

  // One read on channel ch (0 fetch, 1 LSU); entered just after a rising edge.
  task automatic do_read(input bit ch, input logic [AW-1:0] addr, input int rr_delay,
                         output logic [DW-1:0] rd);
    int n;
    bit hs;
    rd = '0;
    drive_ar(ch, 1'b1, addr);
    n = 0; hs = 1'b0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = ch ? (data_ARVALID && data_ARREADY) : (instr_ARVALID && instr_ARREADY);
      n++;
    end
    if (!hs) chk(1'b0, ch ? "data_ar_timeout" : "instr_ar_timeout", 64'(n), 64'd200);
    else if (ch) exp_d.push_back(mem_fn(addr));
    else exp_i.push_back(mem_fn(addr));
    @(posedge clk); #1;
    drive_ar(ch, 1'b0, $urandom);
    if (!hs) return;
    set_rready(ch, rr_delay == 0);
    n = 0; hs = 1'b0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = ch ? (data_RVALID && data_RREADY) : (instr_RVALID && instr_RREADY);
      if (hs) rd = ch ? data_RDATA : instr_RDATA;
      else begin
        @(posedge clk); #1;
        n++;
        if (n >= rr_delay) set_rready(ch, 1'b1);
      end
    end
    if (!hs) chk(1'b0, ch ? "data_r_timeout" : "instr_r_timeout", 64'(n), 64'd200);
    @(posedge clk); #1;
    set_rready(ch, 1'b0);
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout actual=%0t expected=<200000", $time);
    $fatal(1, "bench timed out");
  end

  initial begin : main
    logic [DW-1:0] rd, rd_i, rd_d;
    logic [AW-1:0] a_i, a_d;
    bit            exp_seq[4];
    int            n;
    bit            hs;
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
    instr_ARVALID = 1'b0; instr_ARADDR = '0; instr_RREADY = 1'b0;
    data_ARVALID  = 1'b0; data_ARADDR  = '0; data_RREADY  = 1'b0;
    pulse_reset(3);

    // Fetch-only read of 0x100.
    ar_delay = 0; r_delay = 1;
    do_read(1'b0, 32'h0000_0100, 0, rd);
    chk(rd === 32'hDEAD_BEEF, "fetch_only_rdata", 64'(rd), 64'hDEAD_BEEF);

    // Simultaneous requests straight after reset: LSU first.
    pulse_reset(2);
    grant_log.delete();
    fork
      do_read(1'b0, 32'h0000_0010, 0, rd_i);
      do_read(1'b1, 32'h0000_0200, 0, rd_d);
    join
    chk(grant_log.size() == 2, "simul_grant_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      chk(grant_log[0] == 1'b1, "simul_first_is_lsu", 64'(grant_log[0]), 64'd1);
      chk(grant_log[1] == 1'b0, "simul_second_is_fetch", 64'(grant_log[1]), 64'd0);
    end
    chk(rd_i === mem_fn(32'h10), "simul_fetch_rdata", 64'(rd_i), 64'(mem_fn(32'h10)));
    chk(rd_d === mem_fn(32'h200), "simul_lsu_rdata", 64'(rd_d), 64'(mem_fn(32'h200)));

    // Continuous contention for four transactions.
    grant_log.delete();
    fork
      begin
        do_read(1'b0, 32'h0000_1000, 0, rd_i);
        do_read(1'b0, 32'h0000_1004, 0, rd_i);
      end
      begin
        do_read(1'b1, 32'h0000_2000, 0, rd_d);
        do_read(1'b1, 32'h0000_2004, 0, rd_d);
      end
    join
    chk(grant_log.size() == 4, "alt_grant_count", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < grant_log.size())
        chk(grant_log[k] == exp_seq[k], "alt_grant_order", 64'(grant_log[k]), 64'(exp_seq[k]));

    // Slow address acceptance and a stalled fetch RREADY.
    ar_delay = 3; r_delay = 0;
    do_read(1'b0, 32'h0000_0ABC, 2, rd);
    chk(rd === mem_fn(32'hABC), "stall_rdata", 64'(rd), 64'(mem_fn(32'hABC)));
    chk(exp_i.size() == 0, "stall_no_lost_beat", 64'(exp_i.size()), 64'd0);

    // Reset while the port is in the data phase.
    ar_delay = 0; r_delay = 30;
    drive_ar(1'b0, 1'b1, 32'h0000_0300);
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = instr_ARVALID && instr_ARREADY;
      n++;
    end
    chk(hs, "reset_case_ar_handshake", 64'(hs), 64'd1);
    @(posedge clk); #1;
    drive_ar(1'b0, 1'b0, 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    pulse_reset(1);
    @(negedge clk);
    chk({instr_ARREADY, data_ARREADY, instr_RVALID, data_RVALID, mem_ARVALID, mem_RREADY} == 6'b0,
        "post_reset_quiet",
        64'({instr_ARREADY, data_ARREADY, instr_RVALID, data_RVALID, mem_ARVALID, mem_RREADY}), 64'd0);
    @(posedge clk); #1;
    r_delay = 1;
    do_read(1'b0, 32'h0000_0400, 0, rd);
    chk(rd === mem_fn(32'h400), "post_reset_fetch_rdata", 64'(rd), 64'(mem_fn(32'h400)));

    // Random traffic from both requesters with random memory latencies.
    rand_mem = 1'b1;
    fork
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          a_i = $urandom & 32'hFFFF_FFFC;
          do_read(1'b0, a_i, $urandom_range(0, 3), rd_i);
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          a_d = $urandom & 32'hFFFF_FFFC;
          do_read(1'b1, a_d, $urandom_range(0, 3), rd_d);
        end
      end
    join
    repeat (3) begin @(posedge clk); #1; end
    chk(exp_i.size() == 0, "final_fetch_queue_empty", 64'(exp_i.size()), 64'd0);
    chk(exp_d.size() == 0, "final_lsu_queue_empty", 64'(exp_d.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_read_arbiter.md
CORE_READ_ARBITER -- requirements
Module: core_read_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, address width; SHALL default to the core_pkg value.
REQ-002 Parameter: DATA_WIDTH, 32, data width; SHALL default to the core_pkg value.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_ARADDR  in  ADDR_WIDTH  fetch read address
- instr_ARVALID  in  1  fetch address valid
- instr_ARREADY  out  1  fetch address accepted
- instr_RDATA  out  DATA_WIDTH  fetch read data
- instr_RVALID  out  1  fetch data valid
- instr_RREADY  in  1  fetch data ready
- data_ARADDR  in  ADDR_WIDTH  LSU read address
- data_ARVALID  in  1  LSU address valid
- data_ARREADY  out  1  LSU address accepted
- data_RDATA  out  DATA_WIDTH  LSU read data
- data_RVALID  out  1  LSU data valid
- data_RREADY  in  1  LSU data ready
- mem_ARADDR  out  ADDR_WIDTH  shared memory read address
- mem_ARVALID  out  1  shared address valid
- mem_ARREADY  in  1  memory address accepted
- mem_RDATA  in  DATA_WIDTH  memory read data
- mem_RVALID  in  1  memory data valid
- mem_RREADY  out  1  shared data ready

Function
REQ-004 The block SHALL share one AXI-lite read port between the fetch and LSU read channels, with exactly one outstanding transaction.
REQ-005 The FSM SHALL have states IDLE, ADDR and DATA, plus an owner register (INSTR/DATA) and a last-grant register.
REQ-006 In IDLE with exactly one ARVALID high, that requester SHALL be granted: owner is set and the state moves to ADDR on the next edge.
REQ-007 In IDLE with both ARVALID high, the requester not equal to last-grant SHALL win (round-robin), and last-grant SHALL update to the winner.
REQ-008 In IDLE, every ARREADY, RVALID, mem_ARVALID and mem_RREADY output SHALL be 0, and mem_ARADDR SHALL be 0.
REQ-009 In ADDR:
- mem_ARADDR and mem_ARVALID SHALL follow the owner's ARADDR and ARVALID.
- The owner's ARREADY SHALL equal mem_ARREADY.
- The non-owner's ARREADY SHALL be 0.
- On the mem_ARVALID&mem_ARREADY handshake, the state SHALL move to DATA.
REQ-010 In DATA:
- mem_RREADY SHALL equal the owner's RREADY.
- The owner's RVALID SHALL equal mem_RVALID.
- The non-owner's RVALID SHALL be 0.
- On the mem_RVALID&mem_RREADY handshake, the state SHALL return to IDLE.
REQ-011 instr_RDATA and data_RDATA SHALL both be driven from mem_RDATA at all times; qualification is by RVALID only.
REQ-012 Arbitration latency SHALL be exactly 1 cycle from ARVALID high in IDLE to mem_ARVALID high.
- Back-to-back transactions SHALL incur one IDLE cycle between the R handshake and the next grant.
REQ-013 The non-owner's request SHALL be held pending (ARREADY=0) until the owner's R handshake completes.
- Its ARADDR SHALL be ignored until it is granted.
REQ-014 A request appearing in the same cycle as the owner's R handshake SHALL be arbitrated in the following IDLE cycle.

Reset
REQ-015 On rst=1 at a clock edge, the state SHALL become IDLE, the owner SHALL become INSTR and last-grant SHALL become INSTR.
- As a result, the first simultaneous request goes to the LSU.
REQ-016 Reset during ADDR or DATA SHALL abandon the transaction with no further handshake outputs.
- The memory side is reset by the same rst.
REQ-017 During reset and in the cycle after it, all outputs SHALL hold their REQ-008 values.

Structure
REQ-018 The enums arb_state_t {ARB_IDLE, ARB_ADDR, ARB_DATA} and arb_owner_t {OWN_INSTR, OWN_DATA} SHALL live in core_pkg.
REQ-019 The 2-way round-robin grant logic SHALL be a sub-module, core_rr_arb2, with inputs req[1:0] and last-grant, and output grant.
REQ-020 All routing muxes SHALL be combinational from the state and owner registers; no datapath registers are permitted.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Fetch-only read of 0x100 with mem_RDATA=0xDEADBEEF: grant at cycle+1; instr_RVALID with 0xDEADBEEF; data_RVALID stays 0.
- Simultaneous requests after reset (instr 0x10, data 0x200): LSU is served first; fetch is served after one IDLE cycle.
- Continuous simultaneous requests for 4 transactions: grants alternate DATA, INSTR, DATA, INSTR.
- mem_ARREADY delayed 3 cycles and instr_RREADY low 2 cycles: mem_ARADDR is stable; the state holds; no lost or duplicated beat.
- rst asserted in DATA: the next cycle is IDLE with all valid/ready outputs 0; a following fetch grant is normal.
